// File: rtl/vga_timing.sv
// VGA 800x600@60 timing: pixel counters, frame tick, registered sync and blanked colour output.
// Optional build macro VGA_TESTPAT_EN adds a testMode input that replaces colour with eight vertical bars.
module vga_timing #(
  parameter int unsigned H_VISIBLE = 800,
  parameter int unsigned H_FRONT   = 40,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BACK    = 88,
  parameter int unsigned V_VISIBLE = 600,
  parameter int unsigned V_FRONT   = 1,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BACK    = 23,
  parameter bit          SYNC_POL  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
`ifdef VGA_TESTPAT_EN
  input  logic        testMode,
`endif
  input  logic [3:0]  redIn,
  input  logic [3:0]  greenIn,
  input  logic [3:0]  blueIn,
  output logic [10:0] X,
  output logic [10:0] Y,
  output logic        active,
  output logic        frameTick,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hsync,
  output logic        vsync
);

  localparam int unsigned CW      = 11;
  localparam int unsigned RGB_W   = 12;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CW-1:0]    x_q, x_d;
  logic [CW-1:0]    y_q, y_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic [RGB_W-1:0] rgb_src;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             hs_win, vs_win;

  // Raster counters: X wraps at line end, Y advances on X wrap and wraps at frame end
  always_comb begin
    x_d = x_q + CW'(1);
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + CW'(1);
    end
  end

  assign active    = (x_q < H_VIS) && (y_q < V_VIS);
  assign frameTick = (x_q == '0) && (y_q == V_VIS) && !reset;
  assign hs_win    = (x_q >= HS_START) && (x_q < HS_END);
  assign vs_win    = (y_q >= VS_START) && (y_q < VS_END);

`ifdef VGA_TESTPAT_EN
  localparam int unsigned BAR_W = 100;
  logic [2:0] bar;

  // Bar index is the number of 100-pixel boundaries already passed on this line
  always_comb begin
    bar = 3'd0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (x_q >= CW'(BAR_W * i)) bar = 3'(i);
    end
    rgb_src = testMode ? {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}}
                       : {redIn, greenIn, blueIn};
  end
`else
  assign rgb_src = {redIn, greenIn, blueIn};
`endif

  assign rgb_d   = active ? rgb_src : '0;
  assign hsync_d = hs_win ? SYNC_POL : ~SYNC_POL;
  assign vsync_d = vs_win ? SYNC_POL : ~SYNC_POL;

  // Colour and sync share one register stage so they stay aligned to each other
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      rgb_q   <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign X     = x_q;
  assign Y     = y_q;
  assign red   = rgb_q[11:8];
  assign green = rgb_q[7:4];
  assign blue  = rgb_q[3:0];
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule
